// File: rtl/ysyx_22040759_if_id_stage_if.sv
// Fetch-side handshake bundle between the AXI fetch path and the IF/ID
// pipeline register.
//   if_valid          fetch beat valid            (fetch -> stage)
//   if_pc             PC of the fetch beat        (fetch -> stage)
//   if_inst           instruction of the beat     (fetch -> stage)
//   fetch_outstanding an AXI fetch is in flight   (fetch -> stage)
//   if_ready          stage accepts a beat        (stage -> fetch)
// master = fetch unit, slave = IF/ID stage.
interface ysyx_22040759_if_id_stage_if #(
  parameter int PC_W   = 64,
  parameter int INST_W = 32
);
  logic              if_valid;
  logic [PC_W-1:0]   if_pc;
  logic [INST_W-1:0] if_inst;
  logic              fetch_outstanding;
  logic              if_ready;

  modport master (
    output if_valid, if_pc, if_inst, fetch_outstanding,
    input  if_ready
  );

  modport slave (
    input  if_valid, if_pc, if_inst, fetch_outstanding,
    output if_ready
  );
endinterface

// File: rtl/ysyx_22040759_if_id_stage.sv
// IF/ID pipeline register.
// Accepts fetch beats, holds them under load-use stalls or ID backpressure,
// kills the entry on an EX redirect and, when a fetch was already in flight
// at the redirect, swallows the one stale beat that comes back afterwards.
// Also flags the ID/EX bubble and keeps a saturating count of held cycles.
// Ports:
//   clk, rst        clock; synchronous active-low reset
//   fetch_bus       fetch handshake (slave side): valid/pc/inst/outstanding in,
//                   if_ready out
//   pcwrite         hazard PC freeze, only gates if_ready
//   IF_ID_write     hazard hold of the IF/ID contents
//   en_control      hazard request for an ID/EX bubble
//   flush           EX redirect, kills the entry
//   id_allowin      ID/EX can take the entry
//   id_valid/pc/inst/rs1/rs2   held entry (NOP and x0 when empty)
//   id_bubble       ID/EX must insert a bubble this cycle
//   stall_cycles    saturating count of held cycles
module ysyx_22040759_if_id_stage #(
  parameter int                PC_W     = 64,
  parameter int                INST_W   = 32,
  parameter logic [INST_W-1:0] NOP_INST = 32'h00000013,
  parameter int                CNT_W    = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  ysyx_22040759_if_id_stage_if.slave fetch_bus,
  input  logic                      pcwrite,
  input  logic                      IF_ID_write,
  input  logic                      en_control,
  input  logic                      flush,
  input  logic                      id_allowin,
  output logic                      id_valid,
  output logic [PC_W-1:0]           id_pc,
  output logic [INST_W-1:0]         id_inst,
  output logic [4:0]                id_rs1,
  output logic [4:0]                id_rs2,
  output logic                      id_bubble,
  output logic [CNT_W-1:0]          stall_cycles
);

  // DROP: a redirect happened while a fetch was in flight; the next beat
  // returned is from the wrong path and is consumed without being loaded.
  typedef enum logic {
    S_RUN  = 1'b0,
    S_DROP = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic                valid_q, valid_d;
  logic [PC_W-1:0]     pc_q,    pc_d;
  logic [INST_W-1:0]   inst_q,  inst_d;
  logic [CNT_W-1:0]    cnt_q,   cnt_d;

  logic hold;
  logic ready;
  logic consume;

  // The entry stays put while the hazard unit freezes it or ID cannot take it.
  assign hold = valid_q & (IF_ID_write | ~id_allowin);

  // NOTE: every signal written in an always_comb gets a default on the first
  // line; a path that leaves it unassigned would otherwise infer a latch.
  always_comb begin
    ready = 1'b0;
    if (rst && !flush) begin
      // In DROP the stage is always empty, so the stale beat can be eaten
      // regardless of the PC freeze.
      ready = (state_q == S_DROP) ? 1'b1 : (~hold & ~pcwrite);
    end
  end

  assign fetch_bus.if_ready = ready;
  assign consume            = fetch_bus.if_valid & ready;

  // Next-state and register update. Priority: flush > hold > accept.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    pc_d    = pc_q;
    inst_d  = inst_q;

    if (flush) begin
      valid_d = 1'b0;
      inst_d  = NOP_INST;
      // An in-flight fetch will return a wrong-path beat. A flush already in
      // DROP keeps DROP: still only one beat is owed.
      if (fetch_bus.fetch_outstanding) begin
        state_d = S_DROP;
      end
    end else if (hold) begin
      // keep pc/inst/valid
    end else if (state_q == S_DROP) begin
      if (consume) begin
        state_d = S_RUN;
      end
    end else if (consume) begin
      valid_d = 1'b1;
      pc_d    = fetch_bus.if_pc;
      inst_d  = fetch_bus.if_inst;
    end else begin
      // Not held and nothing new: whatever was here has drained to ID.
      valid_d = 1'b0;
    end
  end

  // Saturating stall counter; a flush in the same cycle cancels the hold.
  always_comb begin
    cnt_d = cnt_q;
    if (hold && !flush && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_RUN;
      valid_q <= 1'b0;
      // pc/inst are reset as well so id_pc/id_inst are defined straight out
      // of reset rather than carrying X into the decoder.
      pc_q    <= '0;
      inst_q  <= NOP_INST;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      cnt_q   <= cnt_d;
    end
  end

  assign id_valid     = valid_q;
  assign id_pc        = pc_q;
  assign id_inst      = valid_q ? inst_q : NOP_INST;
  assign id_rs1       = id_inst[19:15];
  assign id_rs2       = id_inst[24:20];
  // Combinational so the ID/EX control clear sees it in the same cycle.
  assign id_bubble    = valid_q & en_control;
  assign stall_cycles = cnt_q;

endmodule
